fp_issue_ctrl: RTL and testbench
================================

Name: fp_issue_ctrl

Overview:
- Sequences the multi-cycle FP execute unit.
- Accepts FP instructions from decode via a valid/ready handshake, pulses start to the FP datapath and counts the per-op-class latency.
- Presents the result to the register-file writeback port with a valid/ready handshake.
- Tracks the single in-flight destination register so decode can stall on RAW hazards; supports pipeline flush.

Parameters:
- REG_IDX_W, 3, FP register index width.
- LAT_ADD, 3, execute cycles for op class 00 (add/sub); legal range 1..15.
- LAT_MUL, 4, execute cycles for op class 01 (mul); legal range 1..15.
- LAT_DIV, 12, execute cycles for op class 10 (div/sqrt); legal range 1..15.
- LAT_MISC, 1, execute cycles for op class 11 (move/compare/convert); legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  decode presents an FP instruction
- issue_ready  out  1  controller can accept
- issue_op  in  4  AluOp; bits [3:2] select the op class
- issue_rd  in  REG_IDX_W  destination register
- chk_rs1, chk_rs2  in  REG_IDX_W  decode source registers for hazard check
- raw_hazard  out  1  a source matches the pending destination
- flush  in  1  squash the in-flight op
- fpu_start  out  1  one-cycle start pulse to the FP datapath
- fpu_op  out  4  registered op held for the whole operation
- fpu_err  in  1  datapath error flag
- wb_valid  out  1  result ready for writeback
- wb_rd  out  REG_IDX_W  writeback destination
- wb_err  out  1  error accompanying wb_valid
- wb_ready  in  1  register-file port granted
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, pend_valid=0.
  - Output reset values: fpu_start=0, fpu_op=0, wb_valid=0, wb_rd=0, wb_err=0, busy=0.
- States: IDLE, EXEC, WB.
- issue_ready = (state==IDLE) & ~flush.
- Accept = issue_valid & issue_ready, at cycle T.
  - Latch op and rd; set pend_valid=1.
  - Load counter with LAT(class).
  - Go to EXEC; fpu_start=1 and fpu_op valid at T+1 only.
- EXEC:
  - Counter decrements each cycle.
  - Error accumulator ORs in fpu_err every EXEC cycle; it is cleared on accept.
  - When counter reaches 1, go to WB.
  - wb_valid is first high at cycle T+1+LAT (LAT=1 gives wb_valid at T+2).
- WB:
  - wb_valid, wb_rd and wb_err are held stable until wb_ready.
  - Handshake cycle: pend_valid=0; next state IDLE.
- raw_hazard (combinational) = pend_valid & ((chk_rs1==pend_rd) | (chk_rs2==pend_rd)). It stays asserted through WB until the handshake cycle completes.
- flush: in any state, next cycle is IDLE with pend_valid=0 and wb_valid=0.
  - No writeback is issued and no new accept occurs in the flush cycle.
  - Flush in the same cycle as a WB handshake: the handshake is still treated as completed; the controller does not re-present the result.
- issue_valid while not ready: no state change; decode must hold its inputs.
- Reset mid-operation aborts immediately to the reset state; fpu_start is never re-pulsed.

Optional Feature:
- Macro: FPCTRL_B2B_ISSUE_EN.
- Defined: issue_ready = ((state==IDLE) | (state==WB & wb_ready)) & ~flush.
  - A new accept in the WB handshake cycle goes directly to EXEC.
  - pend_rd is overwritten with the new rd; pend_valid stays 1.
  - Zero bubble between operations.
- Undefined: at least one IDLE cycle between a writeback and the next accept.

Decomposition:
- Add to wi23_defs:
  - fp_op_class_e (ADD=2'b00, MUL=2'b01, DIV=2'b10, MISC=2'b11)
  - fpctrl_state_e (IDLE, EXEC, WB)
  - default latency constants FP_LAT_ADD, FP_LAT_MUL, FP_LAT_DIV, FP_LAT_MISC
- Sub-module fp_lat_decode: purely combinational; maps issue_op[3:2] to a 4-bit latency using the parameters. The controller FSM, counter and scoreboard remain in fp_issue_ctrl.

Test Plan:
- Reset, then accept ADD (op=4'b0000, rd=3) at cycle 0 with wb_ready=1 held high:
  - fpu_start high at cycle 1 only.
  - wb_valid high at cycle 4 with wb_rd=3.
  - issue_ready high again at cycle 5.
- Accept DIV (op=4'b1000, rd=5) with wb_ready=0 held for 3 extra cycles:
  - wb_valid high from cycle 13 and held steady with wb_rd=5 through the stall.
  - Returns to IDLE the cycle after wb_ready rises.
- While MUL to rd=2 is in flight, drive chk_rs1=2:
  - raw_hazard=1 through EXEC and WB.
  - raw_hazard drops the cycle after the WB handshake.
  - chk_rs1=4 gives raw_hazard=0.
- Pulse fpu_err for one cycle mid-EXEC of MUL: wb_err=1 with wb_valid. The next ADD without an error gives wb_err=0.
- Flush during EXEC of DIV (cycle 6): wb_valid is never asserted, raw_hazard=0 and busy=0 from cycle 7; issue_valid during the flush cycle is not accepted.
- With FPCTRL_B2B_ISSUE_EN: back-to-back MISC ops rd=1 then rd=6, wb_ready=1:
  - Second accept happens in the first WB cycle.
  - wb_valid pulses for rd=1 and then rd=6 with no IDLE cycle between.
  - Without the macro, one IDLE cycle separates them.

Source files
------------

// File: rtl/fp_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_pkg
// Shared types and default latencies for the FP issue controller.
//   fp_op_class_e  : op class carried in AluOp[3:2]
//   fpctrl_state_e : controller FSM states
//   FP_LAT_*       : default execute latencies per op class (legal 1..15)
// -----------------------------------------------------------------------------
package fp_issue_ctrl_pkg;

    // Latency counter width; every latency must fit in 1..15.
    localparam int LAT_W = 4;

    localparam int FP_LAT_ADD  = 3;
    localparam int FP_LAT_MUL  = 4;
    localparam int FP_LAT_DIV  = 12;
    localparam int FP_LAT_MISC = 1;

    typedef enum logic [1:0] {
        FP_ADD  = 2'b00,
        FP_MUL  = 2'b01,
        FP_DIV  = 2'b10,
        FP_MISC = 2'b11
    } fp_op_class_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } fpctrl_state_e;

endpackage

// File: rtl/fp_issue_ctrl_lat_decode.sv
// -----------------------------------------------------------------------------
// fp_lat_decode
// Purely combinational map from FP op class to execute latency.
// Ports:
//   i_op_class : AluOp[3:2]
//   o_lat      : execute cycles for that class (LAT_W bits)
// -----------------------------------------------------------------------------
module fp_lat_decode
    import fp_issue_ctrl_pkg::*;
#(
    parameter int LAT_ADD  = FP_LAT_ADD,
    parameter int LAT_MUL  = FP_LAT_MUL,
    parameter int LAT_DIV  = FP_LAT_DIV,
    parameter int LAT_MISC = FP_LAT_MISC
) (
    input  logic [1:0]       i_op_class,
    output logic [LAT_W-1:0] o_lat
);

    always_comb begin
        o_lat = LAT_W'(LAT_MISC);
        case (fp_op_class_e'(i_op_class))
            FP_ADD:  o_lat = LAT_W'(LAT_ADD);
            FP_MUL:  o_lat = LAT_W'(LAT_MUL);
            FP_DIV:  o_lat = LAT_W'(LAT_DIV);
            default: o_lat = LAT_W'(LAT_MISC);
        endcase
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl
// Sequences the multi-cycle FP execute unit: accepts one instruction from
// decode, pulses fpu_start, counts the per-class latency, then presents the
// result to the register-file writeback port. Tracks the single in-flight
// destination so decode can stall on RAW hazards. Supports flush.
//
// Optional feature (macro FPCTRL_B2B_ISSUE_EN): accept a new instruction in
// the WB handshake cycle, giving zero bubbles between operations.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   issue_valid/issue_ready   : decode handshake; issue_op, issue_rd payload
//   chk_rs1, chk_rs2          : decode sources; raw_hazard flags a match
//   flush                     : squash the in-flight op
//   fpu_start, fpu_op, fpu_err: FP datapath interface
//   wb_valid/wb_ready         : writeback handshake; wb_rd, wb_err payload
//   busy                      : controller not IDLE
// -----------------------------------------------------------------------------
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 3,
    parameter int LAT_ADD   = FP_LAT_ADD,
    parameter int LAT_MUL   = FP_LAT_MUL,
    parameter int LAT_DIV   = FP_LAT_DIV,
    parameter int LAT_MISC  = FP_LAT_MISC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [3:0]           issue_op,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] chk_rs1,
    input  logic [REG_IDX_W-1:0] chk_rs2,
    output logic                 raw_hazard,
    input  logic                 flush,
    output logic                 fpu_start,
    output logic [3:0]           fpu_op,
    input  logic                 fpu_err,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic                 wb_err,
    input  logic                 wb_ready,
    output logic                 busy
);

    fpctrl_state_e          r_state;
    logic [LAT_W-1:0]       r_cnt;
    logic                   r_pend_valid;
    logic [REG_IDX_W-1:0]   r_pend_rd;
    logic                   r_err_acc;
    logic                   r_fpu_start;
    logic [3:0]             r_fpu_op;
    logic                   r_wb_valid;
    logic [REG_IDX_W-1:0]   r_wb_rd;
    logic                   r_wb_err;

    logic [LAT_W-1:0]       w_lat;
    logic                   w_accept;
    logic                   w_wb_hs;

    fp_lat_decode #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_MISC (LAT_MISC)
    ) u_lat_decode (
        .i_op_class (issue_op[3:2]),
        .o_lat      (w_lat)
    );

    assign w_wb_hs = (r_state == ST_WB) & wb_ready;

`ifdef FPCTRL_B2B_ISSUE_EN
    assign issue_ready = ((r_state == ST_IDLE) | w_wb_hs) & ~flush;
`else
    assign issue_ready = (r_state == ST_IDLE) & ~flush;
`endif

    assign w_accept   = issue_valid & issue_ready;
    assign raw_hazard = r_pend_valid & ((chk_rs1 == r_pend_rd) | (chk_rs2 == r_pend_rd));

    assign fpu_start = r_fpu_start;
    assign fpu_op    = r_fpu_op;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_err    = r_wb_err;
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_pend_valid <= 1'b0;
            r_pend_rd    <= '0;
            r_err_acc    <= 1'b0;
            r_fpu_start  <= 1'b0;
            r_fpu_op     <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_err     <= 1'b0;
        end else begin
            r_fpu_start <= 1'b0;
            if (flush) begin
                // Squash wins over everything, including a same-cycle WB
                // handshake: that result counts as delivered, never re-presented.
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_pend_valid <= 1'b0;
                r_wb_valid   <= 1'b0;
                r_wb_err     <= 1'b0;
            end else begin
                case (r_state)
                    ST_EXEC: begin
                        r_cnt     <= r_cnt - 1'b1;
                        r_err_acc <= r_err_acc | fpu_err;
                        // Counter was loaded with LAT, so the last EXEC cycle
                        // is the one where it reads 1.
                        if (r_cnt <= LAT_W'(1)) begin
                            r_state    <= ST_WB;
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_pend_rd;
                            r_wb_err   <= r_err_acc | fpu_err;
                        end
                    end
                    ST_WB: begin
                        if (wb_ready) begin
                            r_state      <= ST_IDLE;
                            r_pend_valid <= 1'b0;
                            r_wb_valid   <= 1'b0;
                            r_wb_err     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase

                // Accept overrides the IDLE/WB updates above; in the
                // back-to-back case this keeps pend_valid set with the new rd.
                if (w_accept) begin
                    r_state      <= ST_EXEC;
                    r_cnt        <= w_lat;
                    r_fpu_op     <= issue_op;
                    r_pend_rd    <= issue_rd;
                    r_pend_valid <= 1'b1;
                    r_err_acc    <= 1'b0;
                    r_fpu_start  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
module tb_fp_issue_ctrl;

`ifdef FPCTRL_B2B_ISSUE_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] issue_op;
    logic [2:0] issue_rd;
    logic [2:0] chk_rs1;
    logic [2:0] chk_rs2;
    logic       raw_hazard;
    logic       flush;
    logic       fpu_start;
    logic [3:0] fpu_op;
    logic       fpu_err;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic       wb_err;
    logic       wb_ready;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    fp_issue_ctrl #(.REG_IDX_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .raw_hazard  (raw_hazard),
        .flush       (flush),
        .fpu_start   (fpu_start),
        .fpu_op      (fpu_op),
        .fpu_err     (fpu_err),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_err      (wb_err),
        .wb_ready    (wb_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       fl;
        logic       err;
        logic       wr;
        logic       e_rdy;
        logic       e_st;
        logic       e_wv;
        logic [2:0] e_wrd;
        logic       e_werr;
        logic       e_raw;
        logic       e_busy;
        logic [3:0] e_op;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int v, input int op, input int rd, input int rs1,
                                input int rs2, input int fl, input int err, input int wr,
                                input int rdy, input int st, input int wv, input int wrd,
                                input int werr, input int raw, input int bsy, input int eop);
        vec_t r;
        r.v = v[0];       r.op = op[3:0];   r.rd = rd[2:0];    r.rs1 = rs1[2:0];
        r.rs2 = rs2[2:0]; r.fl = fl[0];     r.err = err[0];    r.wr = wr[0];
        r.e_rdy = rdy[0]; r.e_st = st[0];   r.e_wv = wv[0];    r.e_wrd = wrd[2:0];
        r.e_werr = werr[0]; r.e_raw = raw[0]; r.e_busy = bsy[0]; r.e_op = eop[3:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic fl,
                       input logic err, input logic wr);
        issue_valid = v; issue_op = op; issue_rd = rd; chk_rs1 = rs1; chk_rs2 = rs2;
        flush = fl; fpu_err = err; wb_ready = wr;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input vec_t r, input int i);
        chk($sformatf("row%0d_issue_ready", i), 32'(issue_ready), 32'(r.e_rdy));
        chk($sformatf("row%0d_fpu_start", i),   32'(fpu_start),   32'(r.e_st));
        chk($sformatf("row%0d_wb_valid", i),    32'(wb_valid),    32'(r.e_wv));
        chk($sformatf("row%0d_raw_hazard", i),  32'(raw_hazard),  32'(r.e_raw));
        chk($sformatf("row%0d_busy", i),        32'(busy),        32'(r.e_busy));
        if (r.e_wv) begin
            chk($sformatf("row%0d_wb_rd", i),  32'(wb_rd),  32'(r.e_wrd));
            chk($sformatf("row%0d_wb_err", i), 32'(wb_err), 32'(r.e_werr));
        end
        if (r.e_st)
            chk($sformatf("row%0d_fpu_op", i), 32'(fpu_op), 32'(r.e_op));
    endtask

    initial begin
        int start_cyc;
        int wb6_cyc;
        bit acc6;

        // Inputs: v,op,rd,rs1,rs2,fl,err,wr | rdy,start,wv,wrd,werr,raw,busy,fpu_op
        // ADD rd=3, wb_ready held high
        tbl.push_back(mk(1,0,3,7,7,0,0,1, 1,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,3,7,7,0,0,1, 0,1,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,3,7,3,0,0,1, 0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,3,7,7,0,0,1, 0,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,3,3,7,0,0,1, B2B,0,1,3,0,1,1,0));
        tbl.push_back(mk(0,0,3,3,7,0,0,1, 1,0,0,0,0,0,0,0));
        // MUL rd=2: hazard on rs1, fpu_err pulse, one WB stall cycle
        tbl.push_back(mk(1,4,2,2,0,0,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,4,2,2,0,0,0,0, 0,1,0,0,0,1,1,4));
        tbl.push_back(mk(0,4,2,4,4,0,1,0, 0,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,4,2,2,0,0,0,0, 0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,4,2,2,0,0,0,0, 0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,4,2,2,0,0,0,0, 0,0,1,2,1,1,1,0));
        tbl.push_back(mk(0,4,2,2,0,0,0,1, B2B,0,1,2,1,1,1,0));
        tbl.push_back(mk(0,4,2,2,0,0,0,1, 1,0,0,0,0,0,0,0));
        // ADD (low op bits set) rd=1, no error
        tbl.push_back(mk(1,3,1,0,0,0,0,1, 1,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,3,1,0,0,0,0,1, 0,1,0,0,0,0,1,3));
        tbl.push_back(mk(0,3,1,1,0,0,0,1, 0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,3,1,0,0,0,0,1, 0,0,0,0,0,0,1,0));
        tbl.push_back(mk(0,3,1,0,0,0,0,1, B2B,0,1,1,0,0,1,0));
        tbl.push_back(mk(0,3,1,0,0,0,0,1, 1,0,0,0,0,0,0,0));
        // DIV rd=5 flushed at cycle 6 with issue_valid in the flush cycle
        tbl.push_back(mk(1,8,5,5,0,0,0,1, 1,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,8,5,5,0,0,0,1, 0,1,0,0,0,1,1,8));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,8,5,5,0,0,0,1, 0,0,0,0,0,1,1,0));
        tbl.push_back(mk(1,0,6,5,0,1,0,1, 0,0,0,0,0,1,1,0));
        tbl.push_back(mk(0,0,6,5,0,0,0,1, 1,0,0,0,0,0,0,0));
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0,0,0,5,0,0,0,1, 1,0,0,0,0,0,0,0));

        // Reset state
        rst = 1'b1;
        drv(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        to_neg();
        chk("rst_fpu_start",   32'(fpu_start),   32'd0);
        chk("rst_fpu_op",      32'(fpu_op),      32'd0);
        chk("rst_wb_valid",    32'(wb_valid),    32'd0);
        chk("rst_wb_rd",       32'(wb_rd),       32'd0);
        chk("rst_wb_err",      32'(wb_err),      32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_raw_hazard",  32'(raw_hazard),  32'd0);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);
        rst = 1'b0;
        next();

        // Table-driven cycle vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].v, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                tbl[i].fl, tbl[i].err, tbl[i].wr);
            to_neg();
            check_row(tbl[i], i);
            next();
        end

        // DIV rd=5 with wb_ready low for three extra cycles
        drv(1'b1, 4'b1000, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        to_neg();
        chk("div_accept_ready", 32'(issue_ready), 32'd1);
        next();
        for (int c = 1; c <= 17; c++) begin
            drv(1'b0, 4'b1000, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, (c >= 16));
            to_neg();
            if (c < 13) begin
                chk($sformatf("div_c%0d_wb_valid", c), 32'(wb_valid), 32'd0);
            end else if (c <= 16) begin
                chk($sformatf("div_c%0d_wb_valid", c), 32'(wb_valid), 32'd1);
                chk($sformatf("div_c%0d_wb_rd", c),    32'(wb_rd),    32'd5);
                chk($sformatf("div_c%0d_busy", c),     32'(busy),     32'd1);
            end else begin
                chk("div_idle_busy",     32'(busy),        32'd0);
                chk("div_idle_wb_valid", 32'(wb_valid),    32'd0);
                chk("div_idle_ready",    32'(issue_ready), 32'd1);
            end
            next();
        end

        // Back-to-back MISC ops rd=1 then rd=6
        start_cyc = -1;
        wb6_cyc   = -1;
        acc6      = 1'b0;
        drv(1'b1, 4'hC, 3'd1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1);
        to_neg();
        chk("b2b_accept1_ready", 32'(issue_ready), 32'd1);
        next();
        for (int c = 1; c <= 8; c++) begin
            drv((c >= 2) && !acc6, 4'hD, 3'd6, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1);
            to_neg();
            if (c == 1)
                chk("b2b_start1", 32'(fpu_start), 32'd1);
            if (c == 2) begin
                chk("b2b_wb1_valid", 32'(wb_valid),    32'd1);
                chk("b2b_wb1_rd",    32'(wb_rd),       32'd1);
                chk("b2b_wb1_ready", 32'(issue_ready), 32'(B2B));
            end
            if (c == 3)
                chk("b2b_c3_raw", 32'(raw_hazard), 32'(B2B));
            if (fpu_start && (c >= 2) && (start_cyc < 0)) start_cyc = c;
            if (wb_valid && (wb_rd == 3'd6) && (wb6_cyc < 0)) wb6_cyc = c;
            if (issue_valid && issue_ready) acc6 = 1'b1;
            next();
        end
        chk("b2b_start2_cycle", 32'(start_cyc), (B2B != 0) ? 32'd3 : 32'd4);
        chk("b2b_wb6_cycle",    32'(wb6_cyc),   (B2B != 0) ? 32'd4 : 32'd5);

        // Flush coinciding with the WB handshake
        drv(1'b1, 4'hC, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drv(1'b0, 4'hC, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        next();
        drv(1'b0, 4'hC, 3'd4, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1);
        to_neg();
        chk("flhs_wb_valid", 32'(wb_valid),   32'd1);
        chk("flhs_raw",      32'(raw_hazard), 32'd1);
        next();
        for (int c = 0; c < 2; c++) begin
            drv(1'b0, 4'hC, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1);
            to_neg();
            chk($sformatf("flhs_after%0d_wb_valid", c), 32'(wb_valid),   32'd0);
            chk($sformatf("flhs_after%0d_busy", c),     32'(busy),       32'd0);
            chk($sformatf("flhs_after%0d_raw", c),      32'(raw_hazard), 32'd0);
            next();
        end

        // Reset in the middle of a MUL
        drv(1'b1, 4'b0100, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1);
        next();
        drv(1'b0, 4'b0100, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1);
        to_neg();
        chk("rmid_start", 32'(fpu_start), 32'd1);
        next();
        #2 rst = 1'b1;
        #1;
        chk("rmid_busy",      32'(busy),       32'd0);
        chk("rmid_fpu_start", 32'(fpu_start),  32'd0);
        chk("rmid_fpu_op",    32'(fpu_op),     32'd0);
        chk("rmid_raw",       32'(raw_hazard), 32'd0);
        to_neg();
        next();
        to_neg();
        rst = 1'b0;
        next();
        for (int c = 0; c < 8; c++) begin
            to_neg();
            chk($sformatf("rpost%0d_fpu_start", c), 32'(fpu_start), 32'd0);
            chk($sformatf("rpost%0d_wb_valid", c),  32'(wb_valid),  32'd0);
            chk($sformatf("rpost%0d_busy", c),      32'(busy),      32'd0);
            next();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
